// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the data memory: extends loads, splits misaligned accesses.
// Optional MISALIGN_TRAP_EN: misaligned requests complete at once with resp_misaligned=1.
module mem_access_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_misaligned,
  output logic                  busy,
  output logic                  dm_MemRead,
  output logic                  dm_MemWrite,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic [2:0]            dm_Funct3,
  input  logic [DATA_W-1:0]     dm_rd
);

  // state   | meaning
  // IDLE    | waiting for a request, req_ready high
  // LD_LO   | reading the word holding the first byte
  // LD_HI   | reading the following word for a straddling load
  // ST_ONE  | single aligned store
  // ST_BYTE | one byte of a misaligned store per cycle
  // DONE    | one-cycle response
  typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ST_ONE, ST_BYTE, DONE} state_t;

  state_t                r_state, w_next;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic                  r_write;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_w0, r_w1;
  logic [1:0]            r_k;

  // size code: 0 = byte, 1 = halfword, 2 = word
  function automatic logic [1:0] f_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic f_misal(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd1:    return off[0];
      2'd2:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  logic [1:0]            w_req_size, w_size;
  logic                  w_req_misal, w_ld_fits;
  logic [DM_ADDRESS-1:0] w_word_a, w_next_word_a;
  logic [7:0]            w_wbyte;
  logic [2:0]            w_st_f3;
  logic [2*DATA_W-1:0]   w_shifted;
  logic                  w_sign;

  assign w_req_size    = f_size(req_funct3);
  assign w_req_misal   = f_misal(w_req_size, req_addr[1:0]);
  assign w_size        = f_size(r_funct3);
  assign w_ld_fits     = (w_size == 2'd0) || (w_size == 2'd1 && r_addr[1:0] != 2'b11) ||
                         (r_addr[1:0] == 2'b00);
  assign w_word_a      = {r_addr[DM_ADDRESS-1:2], 2'b00};
  assign w_next_word_a = {r_addr[DM_ADDRESS-1:2] + (DM_ADDRESS-2)'(1), 2'b00};
  assign w_wbyte       = 8'(r_wdata >> {r_k, 3'b000});
  assign w_st_f3       = (w_size == 2'd2) ? 3'b010 : r_funct3;
  assign w_shifted     = {r_w1, r_w0} >> {r_addr[1:0], 3'b000};
  assign w_sign        = ~r_funct3[2];

`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  assign resp_misaligned = (r_state == DONE) && r_mis;
`else
  assign resp_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_w0     <= '0;
      r_w1     <= '0;
      r_k      <= '0;
`ifdef MISALIGN_TRAP_EN
      r_mis    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr   <= req_addr[DM_ADDRESS-1:0];
          r_funct3 <= req_funct3;
          r_write  <= req_write;
          r_wdata  <= req_wdata;
          r_w0     <= '0;
          r_w1     <= '0;
          r_k      <= '0;
`ifdef MISALIGN_TRAP_EN
          r_mis    <= w_req_misal;
`endif
        end
        LD_LO:   r_w0 <= dm_rd;
        LD_HI:   r_w1 <= dm_rd;
        ST_BYTE: r_k  <= r_k + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    busy        = 1'b1;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_a        = '0;
    dm_wd       = '0;
    dm_Funct3   = 3'b000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
          if (w_req_misal)    w_next = DONE;
          else if (req_write) w_next = ST_ONE;
          else                w_next = LD_LO;
`else
          if (req_write) w_next = w_req_misal ? ST_BYTE : ST_ONE;
          else           w_next = LD_LO;
`endif
        end
      end
      LD_LO: begin
        dm_MemRead = 1'b1;
        dm_a       = w_word_a;
        dm_Funct3  = 3'b010;
        w_next     = w_ld_fits ? DONE : LD_HI;
      end
      LD_HI: begin
        dm_MemRead = 1'b1;
        dm_a       = w_next_word_a;
        dm_Funct3  = 3'b010;
        w_next     = DONE;
      end
      ST_ONE: begin
        dm_MemWrite = 1'b1;
        dm_a        = r_addr;
        dm_wd       = r_wdata;
        dm_Funct3   = w_st_f3;
        w_next      = DONE;
      end
      ST_BYTE: begin
        dm_MemWrite = 1'b1;
        dm_a        = r_addr + DM_ADDRESS'(r_k);
        dm_wd       = {{(DATA_W-8){1'b0}}, w_wbyte};
        // halfword stores stop after two bytes, words after four
        if (r_k == ((w_size == 2'd1) ? 2'd1 : 2'd3)) w_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
        if (!r_write) begin
          case (w_size)
            2'd0:    resp_rdata = {{(DATA_W-8){w_sign & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    resp_rdata = {{(DATA_W-16){w_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: resp_rdata = w_shifted[DATA_W-1:0];
          endcase
        end
`ifdef MISALIGN_TRAP_EN
        if (r_mis) resp_rdata = '0;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array data memory model.
module tb_mem_access_unit;
  localparam int DMA = 9;
  localparam int DW  = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]     req_funct3 = '0;
  logic [31:0]    req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic           req_ready, resp_valid, resp_misaligned, busy;
  logic [DW-1:0]  resp_rdata, dm_wd, dm_rd;
  logic           dm_MemRead, dm_MemWrite;
  logic [DMA-1:0] dm_a;
  logic [2:0]     dm_Funct3;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_ADDRESS(DMA), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .busy(busy), .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_Funct3(dm_Funct3), .dm_rd(dm_rd)
  );

  logic [7:0]     mem [0:511];
  logic           poke_en = 1'b0;
  logic [DMA-1:0] poke_a = '0;
  logic [31:0]    poke_d = '0;
  logic [DMA-1:0] base;

  always_comb begin
    base  = {dm_a[DMA-1:2], 2'b00};
    dm_rd = {mem[base + 9'd3], mem[base + 9'd2], mem[base + 9'd1], mem[base]};
  end

  always @(posedge clk) begin
    if (poke_en) begin
      for (int i = 0; i < 4; i++) mem[poke_a + 9'(i)] <= poke_d[8*i +: 8];
    end else if (dm_MemWrite) begin
      case (dm_Funct3[1:0])
        2'b00: mem[dm_a] <= dm_wd[7:0];
        2'b01: for (int i = 0; i < 2; i++) mem[dm_a + 9'(i)] <= dm_wd[8*i +: 8];
        default: for (int i = 0; i < 4; i++) mem[dm_a + 9'(i)] <= dm_wd[8*i +: 8];
      endcase
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic        rec_rd [1:10];
  logic        rec_wr [1:10];
  logic [8:0]  rec_a  [1:10];
  logic [31:0] rec_wd [1:10];
  logic [2:0]  rec_f3 [1:10];
  int          resp_cyc, n_acc;
  logic [31:0] resp_dat;
  logic        resp_mis;
  logic        both_seen = 1'b0;

  task automatic mem_poke(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // cycle 1 is the cycle right after the accepting edge
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    resp_cyc = 0; n_acc = 0; resp_dat = '0; resp_mis = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      rec_rd[c] = 1'b0; rec_wr[c] = 1'b0; rec_a[c] = '0; rec_wd[c] = '0; rec_f3[c] = '0;
    end
    for (int c = 1; c <= 10 && resp_cyc == 0; c++) begin
      @(negedge clk);
      rec_rd[c] = dm_MemRead; rec_wr[c] = dm_MemWrite; rec_a[c] = dm_a;
      rec_wd[c] = dm_wd; rec_f3[c] = dm_Funct3;
      if (dm_MemRead || dm_MemWrite) n_acc++;
      if (dm_MemRead && dm_MemWrite) both_seen = 1'b1;
      if (resp_valid) begin
        resp_cyc = c; resp_dat = resp_rdata; resp_mis = resp_misaligned;
      end
    end
  endtask

  logic bad_after_rst;

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {30'd0, dm_MemRead, dm_MemWrite}, 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("rel_ready", 32'(req_ready), 32'd1);

    // aligned LW
    mem_poke(9'h0F0, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h0F0, 0);
    chk("lw_lat", 32'(resp_cyc), 32'd2);
    chk("lw_data", resp_dat, 32'hDEADBEEF);
    chk("lw_acc", {rec_rd[1], rec_a[1], rec_f3[1]}, {1'b1, 9'h0F0, 3'b010});
    chk("lw_nacc", 32'(n_acc), 32'd1);
    @(negedge clk);
    chk("lw_pulse", {30'd0, resp_valid, req_ready}, 32'd1);

    // sign / zero extension
    mem_poke(9'h0F0, 32'h80112233);
    do_req(1'b0, 3'b000, 32'h0F3, 0); chk("lb", resp_dat, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h0F3, 0); chk("lbu", resp_dat, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h0F2, 0); chk("lh", resp_dat, 32'hFFFF8011);
    do_req(1'b0, 3'b101, 32'h0F0, 0); chk("lhu", resp_dat, 32'h00002233);
    chk("lhu_mis", 32'(resp_mis), 32'd0);
    do_req(1'b0, 3'b110, 32'h0F0, 0); chk("f3_110_as_lw", resp_dat, 32'h80112233);

    // misaligned loads
    mem_poke(9'h0F0, 32'hAABBCCDD);
    mem_poke(9'h0F4, 32'h11223344);
    do_req(1'b0, 3'b010, 32'h0F2, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mlw_lat", 32'(resp_cyc), 32'd1);
    chk("mlw_mis", 32'(resp_mis), 32'd1);
    chk("mlw_data", resp_dat, 32'h0);
    chk("mlw_nacc", 32'(n_acc), 32'd0);
`else
    chk("mlw_lat", 32'(resp_cyc), 32'd3);
    chk("mlw_data", resp_dat, 32'h3344AABB);
    chk("mlw_a0", 32'(rec_a[1]), 32'h0F0);
    chk("mlw_a1", {rec_rd[2], rec_a[2]}, {1'b1, 9'h0F4});
    chk("mlw_nacc", 32'(n_acc), 32'd2);
    do_req(1'b0, 3'b001, 32'h0F3, 0);
    chk("mlh3_lat", 32'(resp_cyc), 32'd3);
    chk("mlh3_data", resp_dat, 32'h000044AA);
    do_req(1'b0, 3'b101, 32'h0F1, 0);
    chk("mlhu1_lat", 32'(resp_cyc), 32'd2);
    chk("mlhu1_data", resp_dat, 32'h0000BBCC);
`endif

    // aligned store
    do_req(1'b1, 3'b010, 32'h0F8, 32'hCAFEF00D);
    chk("sw_lat", 32'(resp_cyc), 32'd2);
    chk("sw_acc", {rec_wr[1], rec_a[1], rec_f3[1]}, {1'b1, 9'h0F8, 3'b010});
    chk("sw_rdata", resp_dat, 32'h0);
    do_req(1'b0, 3'b010, 32'h0F8, 0); chk("sw_rb", resp_dat, 32'hCAFEF00D);

`ifndef MISALIGN_TRAP_EN
    // misaligned SW split into bytes
    do_req(1'b1, 3'b010, 32'h0F1, 32'h12345678);
    chk("msw_lat", 32'(resp_cyc), 32'd5);
    chk("msw_b0", {rec_wr[1], rec_a[1], rec_f3[1], rec_wd[1]}, {1'b1, 9'h0F1, 3'b000, 32'h78});
    chk("msw_b1", {rec_wr[2], rec_a[2], rec_wd[2]}, {1'b1, 9'h0F2, 32'h56});
    chk("msw_b2", {rec_wr[3], rec_a[3], rec_wd[3]}, {1'b1, 9'h0F3, 32'h34});
    chk("msw_b3", {rec_wr[4], rec_a[4], rec_f3[4], rec_wd[4]}, {1'b1, 9'h0F4, 3'b000, 32'h12});
    do_req(1'b0, 3'b010, 32'h0F0, 0); chk("msw_rb_lw", resp_dat >> 8, 32'h00345678);
    do_req(1'b0, 3'b000, 32'h0F4, 0); chk("msw_rb_lb", resp_dat, 32'h00000012);

    // misaligned SH
    do_req(1'b1, 3'b001, 32'h0F9, 32'h0000ABCD);
    chk("msh_lat", 32'(resp_cyc), 32'd3);
    chk("msh_nacc", 32'(n_acc), 32'd2);
    do_req(1'b0, 3'b010, 32'h0F8, 0); chk("msh_rb", resp_dat, 32'hCAABCD0D);

    // reset in the middle of a byte-split store
    mem_poke(9'h0F0, 32'hA0A1A2A3);
    mem_poke(9'h0F4, 32'hB0B1B2B3);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0F1; req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstb_k1", {dm_MemWrite, dm_a}, {1'b1, 9'h0F2});
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("rstb_nowr", {30'd0, dm_MemWrite, busy}, 32'd0);
    bad_after_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dm_MemWrite || resp_valid) bad_after_rst = 1'b1;
    end
    reset = 1'b0;
    #1 chk("rstb_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (dm_MemWrite || resp_valid) bad_after_rst = 1'b1;
    end
    chk("rstb_quiet", 32'(bad_after_rst), 32'd0);
    do_req(1'b0, 3'b010, 32'h0F0, 0); chk("rstb_rb_lw", resp_dat, 32'hA0BABEA3);
    do_req(1'b0, 3'b000, 32'h0F4, 0); chk("rstb_rb_lb", resp_dat, 32'hFFFFFFB3);
`endif

    chk("strobe_excl", 32'(both_seen), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
